// File: rtl/ice_arb_pkg.sv
// rtl/ice_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package ice_arb_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int GRANT_W            = 3;
    localparam int CNT_W              = 16;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin search: first set request at or above start, wrapping
module rr_pick
    import ice_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GRANT_W-1:0] start_i,
    output logic [GRANT_W-1:0] idx_o,
    output logic               any_o
);
    localparam int PW = GRANT_W + 1;

    logic [PW-1:0] pos;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // start_i is always < NUM_REQ, so one subtraction folds the wrap
            pos = {1'b0, start_i} + PW'(k);
            if (pos >= PW'(NUM_REQ)) begin
                pos = pos - PW'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_o && (pos == PW'(j)) && req_i[j]) begin
                    any_o = 1'b1;
                    idx_o = GRANT_W'(j);
                end
            end
        end
    end
endmodule

// File: rtl/ice_tx_arbiter.sv
// rtl/ice_tx_arbiter.sv - message-granular round-robin arbiter onto one UART byte stream
module ice_tx_arbiter
    import ice_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   src_valid,
    input  logic [8*NUM_REQ-1:0] src_data,
    input  logic [NUM_REQ-1:0]   src_last,
    output logic [NUM_REQ-1:0]   src_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 abort_pulse
);
    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0] rr_next, pick_idx;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pick_any, hold, sel_valid, sel_last, xfer;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (src_valid),
        .start_i (rr_ptr_q),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign hold     = (state_q == HOLD);
    assign busy     = hold;
    assign grant_id = grant_q;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        tx_data   = '0;
        src_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                if (hold) begin
                    tx_data      = src_data[8*i +: 8];
                    src_ready[i] = tx_ready;
                end
            end
        end
    end

    assign tx_valid = hold & sel_valid;
    assign xfer     = tx_valid & tx_ready;
    assign rr_next  = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + GRANT_W'(1);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        abort_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // a transfer always beats the timeout in the same cycle
                if (xfer) begin
                    cnt_d = '0;
                    if (sel_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_next;
                    end
                end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    rr_ptr_d    = rr_next;
                    cnt_d       = '0;
                    abort_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ice_tx_arbiter.sv
// tb/tb_ice_tx_arbiter.sv - directed self-checking bench for ice_tx_arbiter
module tb_ice_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_valid, src_last, src_ready, src_ready_l;
    logic [31:0] src_data;
    logic        tx_ready;
    logic [7:0]  tx_data, tx_data_l;
    logic        tx_valid, tx_valid_l, busy, busy_l, abort_pulse, abort_pulse_l;
    logic [2:0]  grant_id, grant_id_l;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ice_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
        .src_last(src_last), .src_ready(src_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .grant_id(grant_id), .abort_pulse(abort_pulse)
    );

    ice_tx_arbiter #(.NUM_REQ(4)) dut_l (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
        .src_last(src_last), .src_ready(src_ready_l), .tx_data(tx_data_l),
        .tx_valid(tx_valid_l), .tx_ready(tx_ready), .busy(busy_l),
        .grant_id(grant_id_l), .abort_pulse(abort_pulse_l)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        tx_ready  = 1'b1;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        src_valid = 4'b1111;
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL reset_src_ready: got %b expected 0000", src_ready); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        checks++; if (abort_pulse !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", abort_pulse); end
        reset = 1'b0;
        src_valid = '0;
        tick();
    endtask

    task automatic test_two_sources;
        do_reset();
        src_valid = 4'b1010;
        src_data[15:8]  = 8'hA1;
        src_data[31:24] = 8'hB1;
        src_last = 4'b1000;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL two_arb_latency: tx_valid got %b expected 0", tx_valid); end
        tick();
        #1;
        checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL two_first_grant: got %0d expected 1", grant_id); end
        for (int k = 0; k < 3; k++) begin
            src_data[15:8] = 8'hA1 + 8'(k);
            src_last[1] = (k == 2);
            #1;
            checks++; if (tx_data !== 8'hA1 + 8'(k)) begin errors++; $display("FAIL two_byte%0d: got %h expected %h", k, tx_data, 8'hA1 + 8'(k)); end
            checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL two_ready%0d: got %b expected 0010", k, src_ready); end
            tick();
        end
        src_valid = 4'b1000;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL two_release: busy got %b expected 0", busy); end
        tick();
        #1;
        checks++; if (grant_id !== 3'd3 || tx_data !== 8'hB1) begin errors++; $display("FAIL two_second_grant: got %0d/%h expected 3/b1", grant_id, tx_data); end
        tick();
        src_valid = '0;
    endtask

    task automatic test_round_robin;
        logic [2:0] exp;
        do_reset();
        src_valid = 4'b1111;
        src_last  = 4'b1111;
        src_data  = 32'h13121110;
        for (int n = 0; n < 5; n++) begin
            exp = 3'(n % 4);
            #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: busy got %b expected 0", n, busy); end
            tick();
            #1;
            checks++; if (grant_id !== exp) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", n, grant_id, exp); end
            checks++; if (tx_data !== 8'h10 + 8'(exp)) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", n, tx_data, 8'h10 + 8'(exp)); end
            tick();
        end
        src_valid = '0;
    endtask

    task automatic test_stall;
        do_reset();
        src_valid = 4'b0100;
        src_data[23:16] = 8'hC1;
        tick();
        #1;
        checks++; if (grant_id_l !== 3'd2 || tx_data_l !== 8'hC1) begin errors++; $display("FAIL stall_grant: got %0d/%h expected 2/c1", grant_id_l, tx_data_l); end
        tick();
        src_data[23:16] = 8'hC2;
        src_data[7:0]   = 8'h0F;
        src_valid = 4'b0101;
        src_last  = 4'b0001;
        tx_ready  = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1;
            checks++; if (tx_valid_l !== 1'b1 || tx_data_l !== 8'hC2) begin errors++; $display("FAIL stall_hold%0d: got %b/%h expected 1/c2", n, tx_valid_l, tx_data_l); end
            checks++; if (src_ready_l !== 4'b0000) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0000", n, src_ready_l); end
            tick();
        end
        tx_ready = 1'b1;
        src_last = 4'b0101;
        #1;
        checks++; if (src_ready_l !== 4'b0100) begin errors++; $display("FAIL stall_resume: got %b expected 0100", src_ready_l); end
        tick();
        tick();
        #1;
        checks++; if (grant_id_l !== 3'd0 || tx_data_l !== 8'h0F) begin errors++; $display("FAIL stall_next: got %0d/%h expected 0/0f", grant_id_l, tx_data_l); end
        tick();
        src_valid = '0;
    endtask

    task automatic test_timeout;
        do_reset();
        src_valid = 4'b0001;
        src_data[7:0] = 8'h55;
        tick();
        src_valid = 4'b0010;
        src_last  = 4'b0010;
        src_data[15:8] = 8'h66;
        for (int n = 1; n <= 8; n++) begin
            #1;
            checks++; if (abort_pulse !== (n == 8)) begin errors++; $display("FAIL to_abort%0d: got %b expected %b", n, abort_pulse, (n == 8)); end
            checks++; if (busy !== 1'b1 || grant_id !== 3'd0) begin errors++; $display("FAIL to_hold%0d: got %b/%0d expected 1/0", n, busy, grant_id); end
            tick();
        end
        #1;
        checks++; if (busy !== 1'b0 || abort_pulse !== 1'b0) begin errors++; $display("FAIL to_release: got %b/%b expected 0/0", busy, abort_pulse); end
        tick();
        #1;
        checks++; if (grant_id !== 3'd1 || tx_data !== 8'h66) begin errors++; $display("FAIL to_next: got %0d/%h expected 1/66", grant_id, tx_data); end
        tick();
        src_valid = '0;
    endtask

    task automatic test_timeout_edge;
        do_reset();
        src_valid = 4'b0001;
        src_data[7:0] = 8'h81;
        tick();
        tick();
        src_valid = '0;
        for (int n = 1; n <= 7; n++) begin
            #1;
            checks++; if (abort_pulse !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL edge_wait%0d: got %b/%b expected 0/1", n, abort_pulse, busy); end
            tick();
        end
        src_valid = 4'b0001;
        src_data[7:0] = 8'h82;
        #1;
        checks++; if (abort_pulse !== 1'b0) begin errors++; $display("FAIL edge_abort: got %b expected 0", abort_pulse); end
        checks++; if (src_ready !== 4'b0001 || tx_data !== 8'h82) begin errors++; $display("FAIL edge_xfer: got %b/%h expected 0001/82", src_ready, tx_data); end
        tick();
        src_valid = '0;
        for (int n = 1; n <= 7; n++) begin
            #1;
            checks++; if (abort_pulse !== 1'b0 || busy !== 1'b1 || grant_id !== 3'd0) begin errors++; $display("FAIL edge_cont%0d: got %b/%b/%0d expected 0/1/0", n, abort_pulse, busy, grant_id); end
            tick();
        end
        src_valid = 4'b0001;
        src_last  = 4'b0001;
        src_data[7:0] = 8'h83;
        tick();
        #1;
        checks++; if (busy !== 1'b0 || abort_pulse !== 1'b0) begin errors++; $display("FAIL edge_end: got %b/%b expected 0/0", busy, abort_pulse); end
        src_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        src_valid = 4'b0001;
        src_last  = 4'b0001;
        src_data[7:0] = 8'h60;
        tick();
        tick();
        src_valid = 4'b0010;
        src_last  = 4'b0000;
        src_data[15:8] = 8'h71;
        tick();
        #1;
        checks++; if (grant_id !== 3'd1 || tx_data !== 8'h71) begin errors++; $display("FAIL mid_grant: got %0d/%h expected 1/71", grant_id, tx_data); end
        tick();
        src_data[15:8] = 8'h72;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_drop: got %b/%b expected 0/0", tx_valid, busy); end
        checks++; if (src_ready !== 4'b0000 || abort_pulse !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b/%b expected 0000/0", src_ready, abort_pulse); end
        tick();
        reset = 1'b0;
        src_valid = 4'b0101;
        src_last  = 4'b0101;
        src_data[7:0]   = 8'h60;
        src_data[23:16] = 8'hE2;
        tick();
        #1;
        checks++; if (grant_id !== 3'd0 || tx_data !== 8'h60) begin errors++; $display("FAIL mid_restart: got %0d/%h expected 0/60", grant_id, tx_data); end
        tick();
        src_valid = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_two_sources();
        test_round_robin();
        test_stall();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
